// File: rtl/mem_ctrl.sv
// Single-port byte-RAM controller arbitrating instruction fetch and MEM-stage
// loads/stores; each access is serialised into little-endian byte transfers.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic [4:0]        mem_e,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [2:0]        n_reg, n_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic              wr_reg, wr_next;
  logic              sign_reg, sign_next;
  logic [1:0]        len_reg, len_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       buf_reg, buf_next;
  logic [31:0]       result_reg, result_next;
  logic [31:0]       if_hold_reg, if_hold_next;
  logic [31:0]       mem_hold_reg, mem_hold_next;
  logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;
  logic              ram_wr_reg, ram_wr_next;

  logic [2:0]        cnt_inc;
  logic [31:0]       buf_cap;
  logic [31:0]       wshift;

  // In READ with cnt=k (k>=1), ram_din carries the byte addressed in the
  // previous cycle, which belongs in lane k-1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign buf_cap[8*gi +: 8] = (state_reg == READ && cnt_reg == 3'(gi + 1))
                              ? ram_din : buf_reg[8*gi +: 8];
  end

  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [1:0] len,
                                         input logic sign);
    case (len)
      2'd0:    extend = {{24{sign & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{sign & w[15]}}, w[15:0]};
      2'd2:    extend = {8'h00, w[23:0]};
      default: extend = w;
    endcase
  endfunction

  assign cnt_inc = cnt_reg + 3'd1;
  assign wshift  = wdata_reg >> {cnt_inc[1:0], 3'b000};

  // Flush arriving in the DONE cycle still cancels the fetch completion.
  assign if_done   = (state_reg == DONE) && (owner_reg == OWN_IF) && !if_flush;
  assign mem_done  = (state_reg == DONE) && (owner_reg == OWN_MEM);
  assign if_data   = if_done ? result_reg : if_hold_reg;
  assign mem_rdata = (mem_done && !wr_reg) ? result_reg : mem_hold_reg;
  assign ram_a     = ram_a_reg;
  assign ram_dout  = ram_dout_reg;
  assign ram_wr    = ram_wr_reg;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    n_next        = n_reg;
    base_next     = base_reg;
    wr_next       = wr_reg;
    sign_next     = sign_reg;
    len_next      = len_reg;
    wdata_next    = wdata_reg;
    buf_next      = buf_reg;
    result_next   = result_reg;
    ram_a_next    = ram_a_reg;
    ram_dout_next = ram_dout_reg;
    ram_wr_next   = 1'b0;
    if_hold_next  = if_done ? result_reg : if_hold_reg;
    mem_hold_next = (mem_done && !wr_reg) ? result_reg : mem_hold_reg;

    case (state_reg)
      IDLE: begin
        if (mem_e[4]) begin
          owner_next    = OWN_MEM;
          base_next     = mem_addr;
          len_next      = mem_e[3:2];
          wr_next       = mem_e[1];
          sign_next     = mem_e[0];
          n_next        = {1'b0, mem_e[3:2]} + 3'd1;
          wdata_next    = mem_wdata;
          cnt_next      = 3'd0;
          ram_a_next    = mem_addr;
          ram_wr_next   = mem_e[1];
          ram_dout_next = mem_wdata[7:0];
          state_next    = mem_e[1] ? WRITE : READ;
        end else if (if_req && !if_flush) begin
          owner_next = OWN_IF;
          base_next  = if_addr;
          len_next   = 2'd3;
          wr_next    = 1'b0;
          sign_next  = 1'b0;
          n_next     = 3'd4;
          cnt_next   = 3'd0;
          ram_a_next = if_addr;
          state_next = READ;
        end
      end
      READ: begin
        if (owner_reg == OWN_IF && if_flush) begin
          state_next = IDLE;
        end else begin
          buf_next = buf_cap;
          if (cnt_reg == n_reg) begin
            result_next = extend(buf_cap, len_reg, sign_reg);
            state_next  = DONE;
          end else begin
            cnt_next = cnt_inc;
            if (cnt_inc < n_reg) begin
              ram_a_next = base_reg + ADDR_W'(cnt_inc);
            end
          end
        end
      end
      WRITE: begin
        if (cnt_inc < n_reg) begin
          cnt_next      = cnt_inc;
          ram_a_next    = base_reg + ADDR_W'(cnt_inc);
          ram_dout_next = wshift[7:0];
          ram_wr_next   = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= OWN_IF;
      cnt_reg      <= 3'd0;
      n_reg        <= 3'd0;
      base_reg     <= '0;
      wr_reg       <= 1'b0;
      sign_reg     <= 1'b0;
      len_reg      <= 2'd0;
      wdata_reg    <= 32'd0;
      buf_reg      <= 32'd0;
      result_reg   <= 32'd0;
      if_hold_reg  <= 32'd0;
      mem_hold_reg <= 32'd0;
      ram_a_reg    <= '0;
      ram_dout_reg <= 8'd0;
      ram_wr_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      n_reg        <= n_next;
      base_reg     <= base_next;
      wr_reg       <= wr_next;
      sign_reg     <= sign_next;
      len_reg      <= len_next;
      wdata_reg    <= wdata_next;
      buf_reg      <= buf_next;
      result_reg   <= result_next;
      if_hold_reg  <= if_hold_next;
      mem_hold_reg <= mem_hold_next;
      ram_a_reg    <= ram_a_next;
      ram_dout_reg <= ram_dout_next;
      ram_wr_reg   <= ram_wr_next;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array reference memory predicts load,
// fetch and store-bus results; a negedge monitor pops and compares them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr, if_data;
  logic        if_done;
  logic [4:0]  mem_e;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_wr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { bit load; logic [31:0] data; } mexp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wexp_t;
  logic [31:0] if_q[$];
  mexp_t       mem_q[$];
  wexp_t       wr_q[$];

  logic [7:0] model_mem [0:4095];
  logic [7:0] ram [0:4095];
  bit         ram_valid [0:4095];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .mem_e(mem_e), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    logic [11:0] t;
    t = (a * 12'd37) ^ (a >> 3) ^ 12'h05A;
    return t[7:0];
  endfunction

  // Byte-wide RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram_valid[ram_a[11:0]] ? ram[ram_a[11:0]] : init_byte(ram_a[11:0]);
    if (ram_wr) begin
      ram[ram_a[11:0]]       <= ram_dout;
      ram_valid[ram_a[11:0]] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Reference load: assemble N bytes, then sign-adjust by two's complement.
  function automatic logic [31:0] model_load(input logic [31:0] addr,
                                             input logic [1:0] len, input bit sign);
    int n;
    logic [31:0] v;
    n = int'(len) + 1;
    v = 32'd0;
    for (int k = 0; k < n; k++)
      v = v | (32'(model_mem[12'(addr + 32'(k))]) << (8 * k));
    if (sign && n <= 2 && v[8*n-1])
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (if_done) begin
        if (if_q.size() == 0) flag("if_done_spurious");
        else check("if_data", if_data, if_q.pop_front());
      end
      if (mem_done) begin
        if (mem_q.size() == 0) flag("mem_done_spurious");
        else begin
          mexp_t m;
          m = mem_q.pop_front();
          if (m.load) check("mem_rdata", mem_rdata, m.data);
        end
      end
      if (ram_wr) begin
        if (wr_q.size() == 0) flag("ram_wr_spurious");
        else begin
          wexp_t w;
          w = wr_q.pop_front();
          check("wr_addr", ram_a, w.a);
          check("wr_byte", {24'd0, ram_dout}, {24'd0, w.d});
        end
      end
    end
  end

  task automatic push_expect(input bit is_if, input logic [4:0] e,
                             input logic [31:0] addr, input logic [31:0] wdata);
    mexp_t m;
    int n;
    n = int'(e[3:2]) + 1;
    if (is_if) begin
      if_q.push_back(model_load(addr, 2'd3, 1'b0));
    end else if (e[1]) begin
      for (int k = 0; k < n; k++) begin
        wr_q.push_back('{addr + 32'(k), wdata[8*k +: 8]});
        model_mem[12'(addr + 32'(k))] = wdata[8*k +: 8];
      end
      m.load = 1'b0;
      m.data = 32'd0;
      mem_q.push_back(m);
    end else begin
      m.load = 1'b1;
      m.data = model_load(addr, e[3:2], e[0]);
      mem_q.push_back(m);
    end
  endtask

  task automatic do_req(input bit is_if, input logic [4:0] e,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n, lat, cyc;
    bit wr;
    wr  = !is_if && e[1];
    n   = is_if ? 4 : int'(e[3:2]) + 1;
    lat = is_if ? 6 : (wr ? n + 1 : n + 2);
    push_expect(is_if, e, addr, wdata);
    @(posedge clk); #1;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_e = e; mem_addr = addr; mem_wdata = wdata;
    end
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!wr && cyc <= n) check("ram_a", ram_a, addr + 32'(cyc - 1));
      if (is_if ? if_done : mem_done) break;
    end
    check("latency", 32'(cyc), 32'(lat));
    $display("txn %s e=%b addr=%h wdata=%h if_data=%h mem_rdata=%h cycles=%0d",
             is_if ? "IF " : "MEM", e, addr, wdata, if_data, mem_rdata, cyc);
    if_req = 1'b0;
    mem_e  = 5'd0;
  endtask

  task automatic contention();
    int cyc;
    push_expect(1'b1, 5'd0, 32'h100, 32'd0);
    push_expect(1'b0, 5'b1_11_0_0, 32'h40, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    mem_e = 5'b1_11_0_0; mem_addr = 32'h40;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (mem_done) break;
    end
    check("contention_mem_latency", 32'(cyc), 32'd6);
    mem_e = 5'd0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (if_done) break;
    end
    check("contention_if_latency", 32'(cyc), 32'd7);
    $display("txn contention mem_rdata=%h if_data=%h", mem_rdata, if_data);
    if_req = 1'b0;
  endtask

  task automatic flush_test();
    int seen;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h300;
    repeat (3) begin @(posedge clk); #1; end
    if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(posedge clk); #1;
    check("flush_ram_a_held", ram_a, 32'h302);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if_done) seen++;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    $display("txn flush addr=300");
  endtask

  task automatic reset_test();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    $display("txn reset mid-read addr=10");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) model_mem[i] = init_byte(12'(i));
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'd0;
    mem_e = 5'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ram_a", ram_a, 32'd0);
    check("reset_outputs", {ram_wr, if_done, mem_done, ram_dout}, 11'd0);
    check("reset_data", if_data | mem_rdata, 32'd0);
    rst = 1'b0;

    do_req(1'b0, 5'b1_11_1_0, 32'h100, 32'h00000513);
    do_req(1'b1, 5'd0, 32'h100, 32'd0);
    check("fetch_word_const", if_data, 32'h00000513);
    do_req(1'b0, 5'b1_11_1_0, 32'h40, 32'hDEADBEEF);
    do_req(1'b0, 5'b1_00_1_0, 32'h20, 32'h00000080);
    do_req(1'b0, 5'b1_00_1_0, 32'h21, 32'h0000007F);
    do_req(1'b0, 5'b1_00_0_1, 32'h20, 32'd0);
    check("lb_signed_const", mem_rdata, 32'hFFFFFF80);
    do_req(1'b0, 5'b1_00_0_0, 32'h20, 32'd0);
    do_req(1'b0, 5'b1_01_0_1, 32'h20, 32'd0);
    check("lh_signed_const", mem_rdata, 32'h00007F80);
    do_req(1'b0, 5'b1_10_0_1, 32'h40, 32'd0);

    contention();
    flush_test();
    do_req(1'b1, 5'd0, 32'h200, 32'd0);

    for (int t = 0; t < 80; t++) begin
      bit is_if;
      logic [4:0] e;
      is_if = ($urandom_range(0, 3) == 0);
      e = {1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      do_req(is_if, e, 32'($urandom_range(0, 4000)), $urandom);
    end

    reset_test();
    do_req(1'b1, 5'd0, 32'h100, 32'd0);

    repeat (5) @(posedge clk);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
